// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus an optional iterative shift-add multiplier.
// Define ALU_MC_MUL_EN to compile in the MUL datapath and state; otherwise opcode 1011 is illegal.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] tr,
   input  logic [WIDTH-1:0] sr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dr,
   output logic             cf,
   output logic             of,
   output logic             zf,
   output logic             nf,
   output logic             err
);

   localparam int LW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_CMP = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [3:0] OP_NEG = 4'h6;
   localparam logic [3:0] OP_NOT = 4'h7;
   localparam logic [3:0] OP_SLL = 4'h8;
   localparam logic [3:0] OP_SRL = 4'h9;
   localparam logic [3:0] OP_SRA = 4'hA;
`ifdef ALU_MC_MUL_EN
   localparam logic [3:0] OP_MUL = 4'hB;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1
`ifdef ALU_MC_MUL_EN
      , S_MUL = 2'd2
`endif
   } state_t;

   state_t r_state, w_nextState;

   logic             w_accept;
   logic [WIDTH-1:0] r_dr;
   logic             r_cf, r_of, r_zf, r_nf, r_err;

   logic [WIDTH-1:0] w_dr;
   logic             w_cf, w_of, w_err;
   logic [WIDTH:0]   w_addFull, w_subFull, w_shlFull, w_shrFull, w_sraFull;
   logic [LW-1:0]    w_amt;

   assign w_accept = in_valid & in_ready;
   assign w_amt    = sr[LW-1:0];

`ifdef ALU_MC_MUL_EN
   logic [2*WIDTH-1:0] r_prod, w_prodNext;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH:0]     w_partial;
   logic [LW-1:0]      r_cnt;
   logic               w_mulLast, w_mulHi;

   // Low half of r_prod starts as the multiplier and is consumed one bit per cycle.
   always_comb begin
      w_partial  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
      w_prodNext = {w_partial, r_prod[WIDTH-1:1]};
      w_mulHi    = |w_prodNext[2*WIDTH-1:WIDTH];
      w_mulLast  = (r_state == S_MUL) && (r_cnt == LW'(WIDTH - 1));
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE, S_HOLD: begin
            if (w_accept) begin
`ifdef ALU_MC_MUL_EN
               w_nextState = (op == OP_MUL) ? S_MUL : S_HOLD;
`else
               w_nextState = S_HOLD;
`endif
            end else if ((r_state == S_HOLD) && out_ready) begin
               w_nextState = S_IDLE;
            end
         end
`ifdef ALU_MC_MUL_EN
         S_MUL: if (w_mulLast) w_nextState = S_HOLD;
`endif
         default: w_nextState = S_IDLE;
      endcase
   end

   // A held result may be drained and replaced on the same edge, so HOLD accepts when out_ready is high.
   always_comb begin
      out_valid = (r_state == S_HOLD);
      in_ready  = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
   end

   always_comb begin
      w_addFull = {1'b0, tr} + {1'b0, sr};
      w_subFull = {1'b0, tr} - {1'b0, sr};
      w_shlFull = {1'b0, tr} << w_amt;
      w_shrFull = {tr, 1'b0} >> w_amt;
      w_sraFull = $signed({tr, 1'b0}) >>> w_amt;
      w_dr  = '0;
      w_cf  = 1'b0;
      w_of  = 1'b0;
      w_err = 1'b0;
      case (op)
         OP_ADD: begin
            {w_cf, w_dr} = w_addFull;
            w_of = (tr[WIDTH-1] == sr[WIDTH-1]) && (w_addFull[WIDTH-1] != tr[WIDTH-1]);
         end
         OP_SUB: begin
            {w_cf, w_dr} = w_subFull;
            w_of = (tr[WIDTH-1] != sr[WIDTH-1]) && (w_subFull[WIDTH-1] != tr[WIDTH-1]);
         end
         OP_CMP: begin
            w_dr = {{(WIDTH-1){1'b0}}, (tr == sr)};
            w_cf = (tr < sr);
            w_of = ($signed(tr) < $signed(sr));
         end
         OP_AND: w_dr = tr & sr;
         OP_OR:  w_dr = tr | sr;
         OP_XOR: w_dr = tr ^ sr;
         OP_NEG: begin
            w_dr = '0 - tr;
            w_of = (tr == {1'b1, {(WIDTH-1){1'b0}}});
         end
         OP_NOT: w_dr = ~tr;
         OP_SLL: {w_cf, w_dr} = w_shlFull;
         OP_SRL: {w_dr, w_cf} = w_shrFull;
         OP_SRA: {w_dr, w_cf} = w_sraFull;
         default: w_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dr  <= '0;
         r_cf  <= 1'b0;
         r_of  <= 1'b0;
         r_zf  <= 1'b0;
         r_nf  <= 1'b0;
         r_err <= 1'b0;
`ifdef ALU_MC_MUL_EN
         r_prod  <= '0;
         r_mcand <= '0;
         r_cnt   <= '0;
`endif
      end else begin
         if (w_accept) begin
`ifdef ALU_MC_MUL_EN
            if (op == OP_MUL) begin
               r_prod  <= {{WIDTH{1'b0}}, sr};
               r_mcand <= tr;
               r_cnt   <= '0;
            end else
`endif
            begin
               r_dr  <= w_dr;
               r_cf  <= w_cf;
               r_of  <= w_of;
               r_zf  <= (w_dr == '0);
               r_nf  <= w_dr[WIDTH-1];
               r_err <= w_err;
            end
         end
`ifdef ALU_MC_MUL_EN
         if (r_state == S_MUL) begin
            r_prod <= w_prodNext;
            r_cnt  <= r_cnt + 1'b1;
            if (w_mulLast) begin
               r_dr  <= w_prodNext[WIDTH-1:0];
               r_cf  <= w_mulHi;
               r_of  <= w_mulHi;
               r_zf  <= (w_prodNext[WIDTH-1:0] == '0);
               r_nf  <= w_prodNext[WIDTH-1];
               r_err <= 1'b0;
               r_cnt <= '0;
            end
         end
`endif
      end
   end

   assign dr  = r_dr;
   assign cf  = r_cf;
   assign of  = r_of;
   assign zf  = r_zf;
   assign nf  = r_nf;
   assign err = r_err;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed corner cases, backpressure, reset and
// randomized ops checked against an arithmetic reference model.
module tb_alu_mc;

   localparam int W = 32;
`ifdef ALU_MC_MUL_EN
   localparam bit MulEn = 1'b1;
`else
   localparam bit MulEn = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         inValid, inReady, outValid, outReady;
   logic [3:0]   op;
   logic [W-1:0] tr, sr, dr;
   logic         cf, of, zf, nf, err;

   int checks = 0;
   int passes = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(inValid), .in_ready(inReady),
      .op(op), .tr(tr), .sr(sr),
      .out_valid(outValid), .out_ready(outReady),
      .dr(dr), .cf(cf), .of(of), .zf(zf), .nf(nf), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   o;
      logic [W-1:0] a, b, d;
      logic         c, v, z, n, e;
   } vec_t;

   // Expected {dr, cf, of, zf, nf, err} straight from the arithmetic definition of each opcode.
   function automatic logic [W+4:0] model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] d;
      logic         c, v, e;
      logic [63:0]  wide;
      longint       trueS;
      int           n;
      d = '0; c = 1'b0; v = 1'b0; e = 1'b0;
      case (o)
         4'd0: begin
            wide  = 64'(a) + 64'(b);
            d     = wide[W-1:0];
            c     = wide[W];
            trueS = longint'($signed(a)) + longint'($signed(b));
            v     = (trueS != longint'($signed(d)));
         end
         4'd1: begin
            d     = a - b;
            c     = (a < b);
            trueS = longint'($signed(a)) - longint'($signed(b));
            v     = (trueS != longint'($signed(d)));
         end
         4'd2: begin
            d = (a == b) ? 1 : 0;
            c = (a < b);
            v = ($signed(a) < $signed(b));
         end
         4'd3: d = a & b;
         4'd4: d = a | b;
         4'd5: d = a ^ b;
         4'd6: begin
            d     = 0 - a;
            trueS = -longint'($signed(a));
            v     = (trueS != longint'($signed(d)));
         end
         4'd7: d = ~a;
         4'd8, 4'd9, 4'd10: begin
            n = int'(b % W);
            d = a;
            for (int i = 0; i < n; i++) begin
               if (o == 4'd8) begin
                  c = d[W-1];
                  d = d << 1;
               end else begin
                  c = d[0];
                  d = (o == 4'd9) ? (d >> 1) : {d[W-1], d[W-1:1]};
               end
            end
         end
         4'd11: begin
            if (MulEn) begin
               wide = 64'(a) * 64'(b);
               d    = wide[W-1:0];
               c    = (wide[63:W] != 0);
               v    = c;
            end else begin
               e = 1'b1;
            end
         end
         default: e = 1'b1;
      endcase
      return {d, c, v, (d == '0), d[W-1], e};
   endfunction

   function automatic logic [W-1:0] pickOperand();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Drive one request from a negedge; returns just after the accepting edge.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      inValid = 1'b1;
      op = o;
      tr = a;
      sr = b;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      op = 4'($urandom);
      tr = $urandom;
      sr = $urandom;
   endtask

   task automatic drain();
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
   endtask

   task automatic test_reset();
      logic [W+4:0] exp;
      rst = 1'b1;
      inValid = 1'b0;
      outReady = 1'b0;
      op = '0; tr = '0; sr = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (outValid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b want=0", outValid);
      else passes++;
      checks++;
      if ({dr, cf, of, zf, nf, err} !== '0) $display("[TB] FAIL reset_outputs got=%h want=0", {dr, cf, of, zf, nf, err});
      else passes++;
      checks++;
      if (inReady !== 1'b1) $display("[TB] FAIL reset_in_ready got=%b want=1", inReady);
      else passes++;
      rst = 1'b0;
      @(negedge clk);
      issue(4'd0, 32'd5, 32'd7);
      @(negedge clk);
      exp = model(4'd0, 32'd5, 32'd7);
      checks++;
      if (outValid !== 1'b1 || {dr, cf, of, zf, nf, err} !== exp)
         $display("[TB] FAIL pre_async_add got=%b/%h want=1/%h", outValid, {dr, cf, of, zf, nf, err}, exp);
      else passes++;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (outValid !== 1'b0 || {dr, cf, of, zf, nf, err} !== '0)
         $display("[TB] FAIL async_reset got=%b/%h want=0/0", outValid, {dr, cf, of, zf, nf, err});
      else passes++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      vec_t vecs[$];
      vecs.push_back('{4'h0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{4'h1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{4'h2, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{4'h2, 32'h0000_1234, 32'h0000_1234, 32'h1,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{4'hA, 32'h8000_0001, 32'd33,        32'hC000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{4'h8, 32'h1234_5678, 32'd32,        32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{4'h9, 32'h0000_0003, 32'd1,         32'h1,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{4'h6, 32'h8000_0000, 32'h0,         32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{4'hE, 32'h5,         32'h6,         32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
`ifndef ALU_MC_MUL_EN
      vecs.push_back('{4'hB, 32'h3,         32'h4,         32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
`endif
      foreach (vecs[i]) begin
         issue(vecs[i].o, vecs[i].a, vecs[i].b);
         @(negedge clk);
         checks++;
         if (outValid !== 1'b1 ||
             {dr, cf, of, zf, nf, err} !== {vecs[i].d, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n, vecs[i].e})
            $display("[TB] FAIL directed_%0d op=%h got=%b/%h want=1/%h", i, vecs[i].o, outValid,
                     {dr, cf, of, zf, nf, err},
                     {vecs[i].d, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n, vecs[i].e});
         else passes++;
         drain();
      end
   endtask

   task automatic test_backpressure();
      logic [W+4:0] exp, exp2;
      exp  = model(4'd0, 32'h7FFF_FFFF, 32'h1);
      exp2 = model(4'd5, 32'hA5A5_0F0F, 32'h5A5A_FFFF);
      issue(4'd0, 32'h7FFF_FFFF, 32'h1);
      @(negedge clk);
      checks++;
      if (outValid !== 1'b1 || {dr, cf, of, zf, nf, err} !== exp)
         $display("[TB] FAIL bp_first got=%b/%h want=1/%h", outValid, {dr, cf, of, zf, nf, err}, exp);
      else passes++;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (outValid !== 1'b1 || inReady !== 1'b0 || {dr, cf, of, zf, nf, err} !== exp)
            $display("[TB] FAIL bp_hold_%0d got=%b%b/%h want=10/%h", k, outValid, inReady,
                     {dr, cf, of, zf, nf, err}, exp);
         else passes++;
      end
      outReady = 1'b1;
      inValid = 1'b1;
      op = 4'd5;
      tr = 32'hA5A5_0F0F;
      sr = 32'h5A5A_FFFF;
      #1;
      checks++;
      if (inReady !== 1'b1) $display("[TB] FAIL bp_drain_ready got=%b want=1", inReady);
      else passes++;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      outReady = 1'b0;
      @(negedge clk);
      checks++;
      if (outValid !== 1'b1 || {dr, cf, of, zf, nf, err} !== exp2)
         $display("[TB] FAIL bp_no_bubble got=%b/%h want=1/%h", outValid, {dr, cf, of, zf, nf, err}, exp2);
      else passes++;
      drain();
   endtask

   task automatic test_random();
      logic [3:0]   o;
      logic [W-1:0] a, b;
      logic [W+4:0] exp;
      int           cyc, lat, hold;
      for (int it = 0; it < 150; it++) begin
         o = 4'($urandom_range(0, 15));
         a = pickOperand();
         b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 70)) : pickOperand();
         exp = model(o, a, b);
         // The accepting edge counts as edge 1; MUL lands WIDTH edges after it.
         lat = (MulEn && o == 4'd11) ? W + 1 : 1;
         issue(o, a, b);
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (outValid !== 1'b1 && cyc < 100);
         checks++;
         if (cyc !== lat) $display("[TB] FAIL rand_latency_%0d op=%h got=%0d want=%0d", it, o, cyc, lat);
         else passes++;
         checks++;
         if ({dr, cf, of, zf, nf, err} !== exp)
            $display("[TB] FAIL rand_result_%0d op=%h tr=%h sr=%h got=%h want=%h", it, o, a, b,
                     {dr, cf, of, zf, nf, err}, exp);
         else passes++;
         hold = $urandom_range(0, 2);
         if (hold > 0) begin
            repeat (hold) @(negedge clk);
            checks++;
            if (outValid !== 1'b1 || {dr, cf, of, zf, nf, err} !== exp)
               $display("[TB] FAIL rand_hold_%0d got=%b/%h want=1/%h", it, outValid, {dr, cf, of, zf, nf, err}, exp);
            else passes++;
         end
         drain();
         checks++;
         if (outValid !== 1'b0) $display("[TB] FAIL rand_drain_%0d got=%b want=0", it, outValid);
         else passes++;
      end
   endtask

`ifdef ALU_MC_MUL_EN
   task automatic test_mul();
      logic [W+4:0] exp;
      bit           busyOk;
      busyOk = 1'b1;
      exp = model(4'd11, 32'h10, 32'h11);
      issue(4'd11, 32'h10, 32'h11);
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         if (inReady !== 1'b0 || outValid !== 1'b0) busyOk = 1'b0;
      end
      checks++;
      if (busyOk !== 1'b1) $display("[TB] FAIL mul_busy got=%b want=1", busyOk);
      else passes++;
      @(negedge clk);
      checks++;
      if (outValid !== 1'b1 || {dr, cf, of, zf, nf, err} !== exp)
         $display("[TB] FAIL mul_result got=%b/%h want=1/%h", outValid, {dr, cf, of, zf, nf, err}, exp);
      else passes++;
      drain();
   endtask

   task automatic test_mul_reset();
      logic [W+4:0] exp;
      bit           sawValid;
      issue(4'd11, 32'hFFFF_0000, 32'h0001_0000);
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (outValid !== 1'b0 || inReady !== 1'b1)
         $display("[TB] FAIL mul_rst_immediate got=%b%b want=01", outValid, inReady);
      else passes++;
      @(negedge clk);
      rst = 1'b0;
      sawValid = 1'b0;
      repeat (W + 5) begin
         @(negedge clk);
         if (outValid === 1'b1) sawValid = 1'b1;
      end
      checks++;
      if (sawValid !== 1'b0 || inReady !== 1'b1)
         $display("[TB] FAIL mul_rst_abort got=%b%b want=01", sawValid, inReady);
      else passes++;
      exp = model(4'd0, 32'd2, 32'd3);
      issue(4'd0, 32'd2, 32'd3);
      @(negedge clk);
      checks++;
      if (outValid !== 1'b1 || {dr, cf, of, zf, nf, err} !== exp)
         $display("[TB] FAIL mul_rst_after got=%b/%h want=1/%h", outValid, {dr, cf, of, zf, nf, err}, exp);
      else passes++;
      drain();
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
`ifdef ALU_MC_MUL_EN
      test_mul();
      test_mul_reset();
`endif
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
